// File: rtl/pause_dim_ctrl.sv
// pause_dim_ctrl
// Merges the user pause toggle with external pause requests. After a long
// user pause it fades the core's RGB output down in right-shift steps, and
// it snaps back to full brightness on unpause.
//
// Timing summary (measured in clk_sys edges):
//   edge T        : a rising user_pause is sampled, so the toggle sets and the FSM enters WAIT (timer=0)
//   edge T+DIM    : level 1 (FADE, or DIM when MAX_SHIFT==1)
//   every STEP    : level +1 until MAX_SHIFT (DIM)
//   rgb_out at edge E is rgb_in >> (dim_level held just before E)
module pause_dim_ctrl #(
    parameter int RGB_W       = 4,
    parameter int N_SRC       = 1,
    parameter int DIM_CYCLES  = 480000000,
    parameter int STEP_CYCLES = 4800000,
    parameter int MAX_SHIFT   = 1
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic                             user_pause,
    input  logic [N_SRC-1:0]                 pause_req,
    input  logic                             dim_en,
    input  logic [3*RGB_W-1:0]               rgb_in,
    output logic                             pause,
    output logic                             paused_user,
    output logic [$clog2(MAX_SHIFT+1)-1:0]   dim_level,
    output logic [3*RGB_W-1:0]               rgb_out
);

    localparam int TW = $clog2(DIM_CYCLES + 1);
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int LW = $clog2(MAX_SHIFT + 1);

    // The timer stops at the last wait count and holds there.
    localparam logic [TW-1:0] TIMER_SAT = TW'(DIM_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    // This is the level that sits one step below the final shift.
    localparam logic [LW-1:0] LVL_PEN   = LW'(MAX_SHIFT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FADE = 2'd2,
        ST_DIM  = 2'd3
    } state_t;

    state_t          fsm_state;
    logic            toggle;
    logic            old_p;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   step_cnt;
    logic [LW-1:0]   level;

    logic            user_rise;
    logic            toggle_nx;

    // A rising edge on the pause button flips the toggle. The FSM looks at
    // the post-edge value, so pausing and unpausing act on the same edge that
    // updates the toggle.
    assign user_rise = user_pause & ~old_p;
    assign toggle_nx = toggle ^ user_rise;

    // Button edge detector and user toggle. Reset wins over a coincident edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_p  <= 1'b0;
            toggle <= 1'b0;
        end else begin
            old_p  <= user_pause;
            toggle <= toggle_nx;
        end
    end

    // Dimming FSM. It runs only from the user toggle; external requests never touch it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fsm_state <= ST_RUN;
            timer     <= '0;
            step_cnt  <= '0;
            level     <= '0;
        end else if (!toggle_nx) begin
            // An unpause from any state snaps back to full brightness.
            fsm_state <= ST_RUN;
            timer     <= '0;
            step_cnt  <= '0;
            level     <= '0;
        end else begin
            case (fsm_state)
                ST_RUN: begin
                    fsm_state <= ST_WAIT;
                    timer     <= '0;
                    step_cnt  <= '0;
                    level     <= '0;
                end
                ST_WAIT: begin
                    level <= '0;
                    if (timer == TIMER_SAT && dim_en) begin
                        level     <= LW'(1);
                        step_cnt  <= '0;
                        fsm_state <= (MAX_SHIFT == 1) ? ST_DIM : ST_FADE;
                    end else if (timer != TIMER_SAT) begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_FADE: begin
                    if (!dim_en) begin
                        // Dimming is disabled, so park in WAIT ready to fade again.
                        fsm_state <= ST_WAIT;
                        timer     <= TIMER_SAT;
                        step_cnt  <= '0;
                        level     <= '0;
                    end else if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        level    <= level + LW'(1);
                        if (level == LVL_PEN) begin
                            fsm_state <= ST_DIM;
                        end
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                ST_DIM: begin
                    if (!dim_en) begin
                        fsm_state <= ST_WAIT;
                        timer     <= TIMER_SAT;
                        step_cnt  <= '0;
                        level     <= '0;
                    end
                end
                default: begin
                    fsm_state <= ST_RUN;
                    timer     <= '0;
                    step_cnt  <= '0;
                    level     <= '0;
                end
            endcase
        end
    end

    // Registered video path. Each channel is shifted right by the current level.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= {rgb_in[3*RGB_W-1:2*RGB_W] >> level,
                        rgb_in[2*RGB_W-1:RGB_W]   >> level,
                        rgb_in[RGB_W-1:0]         >> level};
        end
    end

    // External requests pause the core in the same cycle they arrive.
    assign pause       = toggle | (|pause_req);
    assign paused_user = toggle;
    assign dim_level   = level;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Bench for pause_dim_ctrl with DIM_CYCLES=10, STEP_CYCLES=4, MAX_SHIFT=2.
module tb_pause_dim_ctrl;

    localparam int RGB_W       = 4;
    localparam int N_SRC       = 2;
    localparam int DIM_CYCLES  = 10;
    localparam int STEP_CYCLES = 4;
    localparam int MAX_SHIFT   = 2;
    localparam int LW          = $clog2(MAX_SHIFT + 1);

    // Clock and reset
    logic              clk_sys = 1'b0;
    logic              reset;
    logic              user_pause;
    logic [N_SRC-1:0]  pause_req;
    logic              dim_en;
    logic [11:0]       rgb_in;
    logic              pause;
    logic              paused_user;
    logic [LW-1:0]     dim_level;
    logic [11:0]       rgb_out;

    always #5 clk_sys = ~clk_sys;

    pause_dim_ctrl #(
        .RGB_W       (RGB_W),
        .N_SRC       (N_SRC),
        .DIM_CYCLES  (DIM_CYCLES),
        .STEP_CYCLES (STEP_CYCLES),
        .MAX_SHIFT   (MAX_SHIFT)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .user_pause  (user_pause),
        .pause_req   (pause_req),
        .dim_en      (dim_en),
        .rgb_in      (rgb_in),
        .pause       (pause),
        .paused_user (paused_user),
        .dim_level   (dim_level),
        .rgb_out     (rgb_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. It counts edges since the pause began (m_age) and
    // edges since fading began (m_fade, where -1 means no fade). The level
    // follows directly from m_fade.
    bit          m_toggle;
    bit          m_old;
    int          m_age;
    int          m_fade;
    logic [11:0] m_rgb;

    function automatic int m_level();
        int l;
        if (m_fade < 0) return 0;
        l = 1 + m_fade / STEP_CYCLES;
        return (l > MAX_SHIFT) ? MAX_SHIFT : l;
    endfunction

    function automatic logic [11:0] shade(input logic [11:0] c, input int sh);
        logic [3:0] r, g, b;
        r = c[11:8] >> sh;
        g = c[7:4] >> sh;
        b = c[3:0] >> sh;
        return {r, g, b};
    endfunction

    // Advance the model by one clock edge, using the inputs driven right now.
    task automatic model_step();
        bit t_new;
        if (reset) begin
            m_toggle = 1'b0;
            m_old    = 1'b0;
            m_age    = 0;
            m_fade   = -1;
            m_rgb    = '0;
        end else begin
            m_rgb = shade(rgb_in, m_level());
            t_new = m_toggle ^ (user_pause & ~m_old);
            if (!t_new || !m_toggle) begin
                m_age  = 0;
                m_fade = -1;
            end else begin
                if (m_age < 1000000) m_age++;
                if (m_fade >= 0) begin
                    if (!dim_en) m_fade = -1;
                    else if (m_fade < 1000000) m_fade++;
                end else if (m_age >= DIM_CYCLES && dim_en) begin
                    m_fade = 0;
                end
            end
            m_toggle = t_new;
            m_old    = user_pause;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("m_pause", {31'd0, pause}, {31'd0, m_toggle | (|pause_req)});
        check("m_paused_user", {31'd0, paused_user}, {31'd0, m_toggle});
        check("m_dim_level", {30'd0, dim_level}, m_level());
        check("m_rgb_out", {20'd0, rgb_out}, {20'd0, m_rgb});
    endtask

    // Driver: one clock edge, then outputs are sampled 1 ns after it.
    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
        check_model();
    endtask

    typedef struct {
        logic [11:0]      rgb;
        logic [N_SRC-1:0] req;
        logic [11:0]      exp_rgb;
        logic             exp_pause;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // The expected values are for level 2, where each channel is shifted right by 2.
        vecs[0] = '{12'hFFF, 2'b00, 12'h333, 1'b1};
        vecs[1] = '{12'h5A3, 2'b01, 12'h120, 1'b1};
        vecs[2] = '{12'h84C, 2'b10, 12'h213, 1'b1};
        vecs[3] = '{12'h7E9, 2'b11, 12'h132, 1'b1};
        vecs[4] = '{12'h000, 2'b00, 12'h000, 1'b1};
        vecs[5] = '{12'hC3F, 2'b01, 12'h303, 1'b1};

        reset      = 1'b1;
        user_pause = 1'b0;
        pause_req  = '0;
        dim_en     = 1'b1;
        rgb_in     = 12'hFFF;
        m_toggle   = 1'b0;
        m_old      = 1'b0;
        m_age      = 0;
        m_fade     = -1;
        m_rgb      = '0;
        #1;
        tick();
        tick();
        check("rst_rgb", {20'd0, rgb_out}, 32'h0);
        check("rst_pause", {31'd0, pause}, 32'd0);
        check("rst_level", {30'd0, dim_level}, 32'd0);
        reset = 1'b0;

        // Check passthrough with one cycle of latency.
        rgb_in = 12'h5A3;
        tick();
        check("tp1_rgb", {20'd0, rgb_out}, 32'h5A3);
        check("tp1_pause", {31'd0, pause}, 32'd0);
        check("tp1_level", {30'd0, dim_level}, 32'd0);

        // Holding the button flips the toggle only once. The fade reaches level 1 and then level 2.
        rgb_in     = 12'hFFF;
        user_pause = 1'b1;
        tick();
        check("tp2_pause", {31'd0, pause}, 32'd1);
        for (int i = 1; i < 20; i++) begin
            tick();
            if (i == 9)  check("tp2_lvl0_t9", {30'd0, dim_level}, 32'd0);
            if (i == 10) check("tp2_lvl1", {30'd0, dim_level}, 32'd1);
            if (i == 11) check("tp2_rgb777", {20'd0, rgb_out}, 32'h777);
            if (i == 13) check("tp2_lvl1_t13", {30'd0, dim_level}, 32'd1);
            if (i == 14) check("tp2_lvl2", {30'd0, dim_level}, 32'd2);
            if (i == 15) check("tp2_rgb333", {20'd0, rgb_out}, 32'h333);
            if (i == 19) check("tp2_toggle_once", {31'd0, paused_user}, 32'd1);
        end
        user_pause = 1'b0;
        tick();
        check("tp2_hold_lvl2", {30'd0, dim_level}, 32'd2);

        // Drive the table of vectors through the DIM state.
        for (int v = 0; v < 6; v++) begin
            rgb_in    = vecs[v].rgb;
            pause_req = vecs[v].req;
            tick();
            check($sformatf("vec%0d_rgb", v), {20'd0, rgb_out}, {20'd0, vecs[v].exp_rgb});
            check($sformatf("vec%0d_pause", v), {31'd0, pause}, {31'd0, vecs[v].exp_pause});
        end
        pause_req = '0;
        rgb_in    = 12'hFFF;

        // Unpause from DIM. The level drops at once and the picture recovers one cycle later.
        user_pause = 1'b1;
        tick();
        check("tp3_level0", {30'd0, dim_level}, 32'd0);
        check("tp3_pause0", {31'd0, pause}, 32'd0);
        user_pause = 1'b0;
        tick();
        check("tp3_rgbfff", {20'd0, rgb_out}, 32'hFFF);
        user_pause = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 9)  check("tp3_rewait_lvl0", {30'd0, dim_level}, 32'd0);
            if (i == 10) check("tp3_rewait_lvl1", {30'd0, dim_level}, 32'd1);
        end
        user_pause = 1'b0;
        tick();
        user_pause = 1'b1;
        tick();
        user_pause = 1'b0;
        tick();

        // External request: pause changes in the same cycle and there is no dimming.
        pause_req = 2'b10;
        #1;
        check("tp4_pause_on", {31'd0, pause}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("tp4_level", {30'd0, dim_level}, 32'd0);
            check("tp4_rgb", {20'd0, rgb_out}, 32'hFFF);
        end
        pause_req = 2'b00;
        #1;
        check("tp4_pause_off", {31'd0, pause}, 32'd0);

        // With dim_en low there is no dimming. Raising it fades at once; dropping it in FADE clears the level.
        dim_en     = 1'b0;
        user_pause = 1'b1;
        tick();
        user_pause = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("tp5_nodim", {30'd0, dim_level}, 32'd0);
        end
        dim_en = 1'b1;
        tick();
        check("tp5_dim_rise", {30'd0, dim_level}, 32'd1);
        tick();
        dim_en = 1'b0;
        tick();
        check("tp5_dim_drop", {30'd0, dim_level}, 32'd0);
        dim_en = 1'b1;
        tick();
        check("tp5_dim_again", {30'd0, dim_level}, 32'd1);

        // Assert reset on the same edge as a button press, while in FADE.
        reset      = 1'b1;
        user_pause = 1'b1;
        tick();
        check("tp6_toggle", {31'd0, paused_user}, 32'd0);
        check("tp6_level", {30'd0, dim_level}, 32'd0);
        check("tp6_rgb", {20'd0, rgb_out}, 32'h0);
        reset      = 1'b0;
        user_pause = 1'b0;
        tick();
        check("tp6_no_toggle", {31'd0, paused_user}, 32'd0);
        check("tp6_pass", {20'd0, rgb_out}, 32'hFFF);

        // Random stimulus, checked against the model on every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) user_pause = ~user_pause;
            if ($urandom_range(0, 15) == 0) pause_req = ($urandom_range(0, 2) == 0) ? N_SRC'($urandom) : '0;
            if ($urandom_range(0, 63) == 0) dim_en = ~dim_en;
            reset  = ($urandom_range(0, 499) == 0);
            rgb_in = 12'($urandom);
            tick();
        end

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pause_dim_ctrl.md
Name: pause_dim_ctrl

Overview:
- Generalised pause and screen-dim controller for arcade cores, placed between the game core's RGB output and arcade_video.
- Merges a user pause toggle with N external pause requests (hiscore RAM access, OSD, etc.) into one pause line.
- After a programmable idle time in user pause, fades the picture down in discrete shift levels.
- Restores full brightness on unpause.

Parameters:
- RGB_W, 4, bits per colour channel.
- N_SRC, 1, number of external pause request inputs.
- DIM_CYCLES, 480000000, clk_sys cycles of user pause before fading starts (10 s @ 48 MHz).
- STEP_CYCLES, 4800000, clk_sys cycles between successive fade levels.
- MAX_SHIFT, 1, final right-shift applied to each channel; range 1..RGB_W.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- user_pause  in  1  level from the joystick pause button; rising edge toggles pause.
- pause_req  in  N_SRC  external pause requests, level-sensitive.
- dim_en  in  1  1 = dimming allowed; 0 = never dim.
- rgb_in  in  3*RGB_W  {r,g,b} from the core.
- pause  out  1  pause to the core.
- paused_user  out  1  current user toggle state.
- dim_level  out  $clog2(MAX_SHIFT+1)  current shift amount.
- rgb_out  out  3*RGB_W  {r,g,b} after dimming, registered.

Behaviour:
- Reset values: toggle=0, edge register=0, timer=0, fsm=RUN, dim_level=0, rgb_out=0, pause=0, paused_user=0.
- Edge detect: old_p <= user_pause each cycle. If user_pause & ~old_p, the toggle flips on the next edge. Reset has priority over a coincident edge.
- pause = toggle | (|pause_req). This is combinational from registered toggle and raw pause_req, so a request asserts pause in the same cycle.
- Only the user toggle drives dimming; pause_req never starts or advances the timer.
- Timer width is $clog2(DIM_CYCLES+1). It saturates and never wraps.
- Step counter width is $clog2(STEP_CYCLES+1).
- FSM states and transitions:
  - RUN: timer=0, level=0. Goes to WAIT when toggle=1.
  - WAIT: timer increments each cycle. When timer reaches DIM_CYCLES-1 and dim_en=1, go to FADE with level=1 and step counter=0. If timer saturates while dim_en=0, hold in WAIT; once dim_en rises, enter FADE on the next cycle.
  - FADE: step counter increments. At STEP_CYCLES-1, level increments and the counter clears. When level reaches MAX_SHIFT, go to DIM.
  - DIM: hold level=MAX_SHIFT.
  - From any non-RUN state: toggle=0 returns to RUN next cycle with level=0 and timer=0 (no fade-back).
  - From any non-RUN state: dim_en=0 forces level=0 and returns to WAIT with the timer held saturated.
- MAX_SHIFT=1 skips FADE dwell: WAIT goes directly to DIM with level=1.
- rgb_out <= each channel of rgb_in >> dim_level (logical shift, zero-fill), one clk_sys latency. dim_level used is the registered value from the same edge.
- rgb_out updates every cycle, including while paused.
- Re-pausing after unpause restarts the timer from 0.
- Reset mid-fade: next cycle level=0 and rgb_out=0, then passthrough resumes.

Test Plan (DIM_CYCLES=10, STEP_CYCLES=4, MAX_SHIFT=2, RGB_W=4, N_SRC=2, dim_en=1, rgb_in=12'hFFF unless stated):
1. Reset, then drive rgb_in=12'h5A3 -> rgb_out=12'h5A3 one cycle later; pause=0; dim_level=0.
2. Pulse user_pause 0→1→(held 1 for 20 cycles) -> toggle flips once only; pause=1. dim_level becomes 1 10 cycles after the toggle (rgb_out=12'h777 the cycle after), then 2 a further 4 cycles later (rgb_out=12'h333) and stays 2.
3. In DIM state, pulse user_pause again -> next cycle dim_level=0, pause=0; one cycle later rgb_out=12'hFFF. Re-pause -> 10-cycle wait repeats from zero.
4. With toggle=0, assert pause_req=2'b10 for 50 cycles -> pause=1 in the same cycle; dim_level stays 0; rgb_out unchanged. Deassert -> pause=0 in the same cycle.
5. Toggle pause with dim_en=0 for 30 cycles -> dim_level=0. Raise dim_en -> level=1 on the next cycle; drop dim_en in FADE -> level=0 the next cycle.
6. Assert reset in the same cycle as a user_pause rising edge during FADE -> toggle=0, dim_level=0, rgb_out=0 after that edge; no toggle occurs when reset releases.
